// File: rtl/jk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jk_ctrl_pkg
// Shared types and helpers for the JK flip-flop counter controller.
//   state_e    : controller states (IDLE, RUN, PAUSE, CLEAR)
//   jk_pair_t  : per-bit J and K vectors, MAX_WIDTH bits each
//   jk_excite  : J/K excitation that moves a bank from q to target t
//   mod_step   : next count value for a mod-N up/down counter
// Helpers work on MAX_WIDTH-bit vectors. Callers zero-extend their operands
// and slice the result back down to the bank width.
// ---------------------------------------------------------------------------
package jk_ctrl_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        CLEAR = 2'd3
    } state_e;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] j;
        logic [MAX_WIDTH-1:0] k;
    } jk_pair_t;

    // Set only the bits that must rise and reset only the bits that must
    // fall. J and K are therefore never both high on one bit, so the bank
    // never sees a toggle request.
    function automatic jk_pair_t jk_excite(input logic [MAX_WIDTH-1:0] q,
                                           input logic [MAX_WIDTH-1:0] t);
        jk_pair_t r;
        r.j = ~q & t;
        r.k = q & ~t;
        return r;
    endfunction

    // Returns 0 for an out-of-range count. Such a count can occur only when
    // the modulus is below 2^WIDTH.
    function automatic logic [MAX_WIDTH-1:0] mod_step(input logic [MAX_WIDTH-1:0] count,
                                                      input logic                 up_dn,
                                                      input logic [MAX_WIDTH-1:0] modulus);
        logic [MAX_WIDTH-1:0] r;
        if (count >= modulus) begin
            r = '0;
        end else if (up_dn) begin
            r = (count == modulus - 1) ? '0 : count + 1;
        end else begin
            r = (count == '0) ? modulus - 1 : count - 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jk_ff.sv
// ---------------------------------------------------------------------------
// jk_ff
// A single JK flip-flop with an asynchronous active-low reset.
//   J, K    : excitation inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, forces q to 0
//   q       : flip-flop output
// ---------------------------------------------------------------------------
module jk_ff (
    input  logic J,
    input  logic K,
    input  logic clock,
    input  logic reset_n,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        unique case ({J, K})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// ---------------------------------------------------------------------------
// jk_counter_ctrl
// Drives a bank of WIDTH JK flip-flops so that the bank counts modulo
// MODULUS, up or down, with run, pause and clear control, a synchronous
// load and a terminal-count flag. This block owns every J and K line.
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   start    : begin or resume counting (level)
//   stop     : pause while running, clear while paused (level, wins over start)
//   up_dn    : 1 = count up, 0 = count down
//   load     : load load_val this cycle (clamped to MODULUS-1), wins over stop/start
//   load_val : value to load
//   count    : flip-flop bank outputs
//   j_vec    : J inputs driven to the bank
//   k_vec    : K inputs driven to the bank
//   tc       : high while the next RUN edge will wrap
//   busy     : high in any state other than IDLE
// MODULUS must satisfy 2 <= MODULUS <= 2^WIDTH, with WIDTH < 32.
// ---------------------------------------------------------------------------
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             busy
);

    localparam logic [MAX_WIDTH-1:0] MOD_EXT  = MAX_WIDTH'(MODULUS);
    localparam logic [MAX_WIDTH-1:0] LAST_EXT = MAX_WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0]     LAST_W   = WIDTH'(MODULUS - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     q_w;
    logic [WIDTH-1:0]     target;
    logic [WIDTH-1:0]     j_w, k_w;
    logic [WIDTH-1:0]     step_w, load_tgt_w;
    logic [MAX_WIDTH-1:0] q_ext, lv_ext, step_ext, load_tgt_ext;
    logic                 clear_all;
    jk_pair_t             exc;

    // ------------------------------------------------------------------
    // Flip-flop bank
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        jk_ff u_ff (
            .J       (j_w[gi]),
            .K       (k_w[gi]),
            .clock   (clock),
            .reset_n (reset_n),
            .q       (q_w[gi])
        );
    end

    // ------------------------------------------------------------------
    // Candidate targets
    // ------------------------------------------------------------------
    assign q_ext        = MAX_WIDTH'(q_w);
    assign lv_ext       = MAX_WIDTH'(load_val);
    assign step_ext     = mod_step(q_ext, up_dn, MOD_EXT);
    assign load_tgt_ext = (lv_ext >= MOD_EXT) ? LAST_EXT : lv_ext;
    assign step_w       = step_ext[WIDTH-1:0];
    assign load_tgt_w   = load_tgt_ext[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Controller state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, target and excitation
    // The default target equals the current count, so the bank holds
    // (J=K=0) unless a branch below selects a different value.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        target    = q_w;
        clear_all = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    target = load_tgt_w;
                end else if (!stop && start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    target = load_tgt_w;
                end else if (stop) begin
                    state_d = PAUSE;
                end else begin
                    target = step_w;
                end
            end
            PAUSE: begin
                if (load) begin
                    target = load_tgt_w;
                end else if (stop) begin
                    state_d = CLEAR;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            CLEAR: begin
                clear_all = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        exc = jk_excite(MAX_WIDTH'(q_w), MAX_WIDTH'(target));

        if (clear_all) begin
            j_w = '0;
            k_w = '1;
        end else begin
            j_w = exc.j[WIDTH-1:0];
            k_w = exc.k[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // The observed J/K lines are gated by reset_n. This holds them at 0
    // for the whole reset, even if load is asserted during it. The bank
    // itself is held at 0 by its own asynchronous reset.
    // ------------------------------------------------------------------
    assign count = q_w;
    assign j_vec = reset_n ? j_w : '0;
    assign k_vec = reset_n ? k_w : '0;
    assign tc    = (state_q == RUN) && !load && (q_w == (up_dn ? LAST_W : '0));
    assign busy  = (state_q != IDLE);

endmodule
